mode_sequencer: RTL and testbench
=================================

MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of enable channels (ch 0 = power supply, ch 1..N_CH-1 = signal-path channels); legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 50000, wait-state watchdog limit in clk cycles; legal range 2..65535.
REQ-003 SHALL have parameter UFM_RST_CYC, default 4, number of cycles UFM reset is held in state 1; legal range 1..15.
REQ-004 SHALL have parameter READ_WORDS, default 6, UFM words required before leaving state 4.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 sw_reset, sw_enable  in  1 each  debounced switch levels.
REQ-008 sw_reset_rise, sw_enable_rise  in  1 each  one-cycle rising-edge pulses.
REQ-009 pot_init, clk_init  in  1 each  potentiometer and clock generator have finished their reset sequences.
REQ-010 csr_done, pot_cfg_done  in  1 each  UFM CSR configuration and potentiometer initial configuration are complete.
REQ-011 write_done  in  1  UFM program write is complete.
REQ-012 read_count  in  8  UFM words read so far.
REQ-013 pot_loaded, clk_loaded  in  1 each  setpoint and frequency have been loaded.
REQ-014 clk_idle, clk_running  in  1 each  clock generator is disabled or running.
REQ-015 ov_wr  in  1  override write strobe.
REQ-016 ov_mask, ov_value  in  N_CH each  override channel select and the value to apply.
REQ-017 ov_clear  in  1  release all overrides.
REQ-018 controlstate  out  4  current state code.
REQ-019 ufm_reset_n  out  1  active-low UFM reset.
REQ-020 prog_led  out  2  LED mode: 00 off, 01 blink, 10 on.
REQ-021 ch_en  out  N_CH  final channel enables.
REQ-022 fault  out  1  watchdog fault flag.
REQ-023 fault_code  out  4  state code that timed out.

Function
REQ-024 States SHALL be: 0 RST1, 1 RST2, 2 RST3, 3 PROG1, 4 PROG2, 5 PROG3, 6 INACTIVE, 7 ACTIVE, 8 FAULT. Codes 9..F SHALL go to 0 on the next cycle.
REQ-025 sw_reset_rise SHALL force state 0 from any state, including FAULT, and take precedence over every other transition.
REQ-026 Transition 0->1 SHALL occur when sw_enable_rise && sw_reset.
REQ-027 Transition 1->2 SHALL occur when the UFM reset hold is finished && pot_init && clk_init.
REQ-028 Transition 2->3 SHALL occur when csr_done && pot_cfg_done.
REQ-029 Transition 3->4 SHALL occur when write_done.
REQ-030 Transition 4->5 SHALL occur when read_count >= READ_WORDS.
REQ-031 Transition 5->6 SHALL occur when pot_loaded && clk_loaded && !sw_reset && !sw_enable.
REQ-032 Transition 6->7 SHALL occur when clk_idle && !sw_reset && sw_enable_rise.
REQ-033 Transition 7->4 SHALL occur when clk_running && !sw_reset && !sw_enable.
REQ-034 ufm_reset_n SHALL be low in state 0 and for the first UFM_RST_CYC cycles of state 1, then high.
REQ-035 prog_led SHALL be 00 in states 0 and 8, 01 in state 3, and 10 from the cycle state 3->4 is taken; it SHALL hold its value in all other states.
REQ-036 The internal FSM enables fsm_en SHALL clear to 0 in states 0, 6 and 8.
REQ-037 In state 7, fsm_en[0] SHALL be 1, and fsm_en[k>=1] SHALL be set while clk_running && sw_enable && !sw_reset.
REQ-038 fsm_en SHALL hold its value in states 1..5.
REQ-039 The watchdog counter SHALL clear on every state change.
REQ-040 The watchdog counter SHALL count in states 1, 2 and 4, and in state 5 while !(pot_loaded && clk_loaded); in all other states it SHALL hold at 0.
REQ-041 When the watchdog count reaches TIMEOUT-1 and the exit condition is false that cycle, the next cycle SHALL enter FAULT with fault=1 and fault_code = the timed-out state.
REQ-042 If the exit condition and the timeout occur in the same cycle, the normal transition SHALL win.
REQ-043 fault and fault_code SHALL hold until reset or sw_reset_rise clears them to 0.
REQ-044 Each channel SHALL have registered override state ov_act[k] and ov_val[k].
REQ-045 On ov_wr, every channel with ov_mask[k]=1 SHALL take ov_act[k]<=1 and ov_val[k]<=ov_value[k]; other channels SHALL be unchanged.
REQ-046 ov_clear or sw_reset_rise SHALL clear all ov_act; clear SHALL win over a simultaneous ov_wr.
REQ-047 ch_en[k] SHALL equal ov_act[k] ? ov_val[k] : fsm_en[k], except that in FAULT ch_en SHALL be all zero regardless of overrides.
REQ-048 Overrides SHALL be accepted in every state, including FAULT, where they are stored but masked.

Reset
REQ-049 On reset: controlstate=0, ufm_reset_n=0, prog_led=00, ch_en=0, fsm_en=0, ov_act=0, ov_val=0, fault=0, fault_code=0, watchdog=0, hold counter=0.
REQ-050 reset SHALL take precedence over sw_reset_rise and all other inputs.

Verification
REQ-051 Full bring-up (N_CH=2): reset, then sw_reset=1 with an sw_enable_rise pulse, then all done/loaded inputs pulsed in order, then both switches dropped, then sw_enable_rise with clk_idle -> state sequence 0,1,2,3,4,5,6,7; ufm_reset_n low for exactly 4 cycles in state 1; ch_en=01 in state 7 until clk_running, then 11.
REQ-052 Watchdog: TIMEOUT=10, hold pot_init=0 in state 1 -> FAULT exactly 10 cycles after entering state 1, fault_code=1, ch_en=00; then sw_reset_rise -> state 0 and fault=0.
REQ-053 Override: in state 6, ov_wr with ov_mask=10 and ov_value=10 -> ch_en=10; then ov_wr and ov_clear together -> ch_en=00 and ov_act=00.
REQ-054 Fault masking: override ch_en=11, then force a timeout -> ch_en=00 in FAULT; override state retained (ov_act=11 readable after the next sw_reset_rise clears it -> 00).
REQ-055 Re-program loop: in state 7, drop sw_enable with clk_running -> state 4, ch_en unchanged; read_count=6 -> state 5.
REQ-056 Illegal state: force controlstate=4'hB -> state 0 on the next cycle; sw_reset_rise mid-PROG1 -> state 0, prog_led=00.

Source files
------------

// File: rtl/mode_sequencer_if.sv
// Status, override and result signals of the mode sequencer, bundled for the top-level port.
interface mode_sequencer_if #(
    parameter int N_CH = 2
);
    logic            sw_reset;
    logic            sw_enable;
    logic            sw_reset_rise;
    logic            sw_enable_rise;
    logic            pot_init;
    logic            clk_init;
    logic            csr_done;
    logic            pot_cfg_done;
    logic            write_done;
    logic [7:0]      read_count;
    logic            pot_loaded;
    logic            clk_loaded;
    logic            clk_idle;
    logic            clk_running;
    logic            ov_wr;
    logic [N_CH-1:0] ov_mask;
    logic [N_CH-1:0] ov_value;
    logic            ov_clear;

    logic [3:0]      controlstate;
    logic            ufm_reset_n;
    logic [1:0]      prog_led;
    logic [N_CH-1:0] ch_en;
    logic            fault;
    logic [3:0]      fault_code;
    logic [N_CH-1:0] ov_act_dbg;
    logic [N_CH-1:0] fsm_en_dbg;

    modport master (
        output sw_reset, sw_enable, sw_reset_rise, sw_enable_rise,
        output pot_init, clk_init, csr_done, pot_cfg_done, write_done, read_count,
        output pot_loaded, clk_loaded, clk_idle, clk_running,
        output ov_wr, ov_mask, ov_value, ov_clear,
        input  controlstate, ufm_reset_n, prog_led, ch_en, fault, fault_code,
        input  ov_act_dbg, fsm_en_dbg
    );

    modport slave (
        input  sw_reset, sw_enable, sw_reset_rise, sw_enable_rise,
        input  pot_init, clk_init, csr_done, pot_cfg_done, write_done, read_count,
        input  pot_loaded, clk_loaded, clk_idle, clk_running,
        input  ov_wr, ov_mask, ov_value, ov_clear,
        output controlstate, ufm_reset_n, prog_led, ch_en, fault, fault_code,
        output ov_act_dbg, fsm_en_dbg
    );
endinterface

// File: rtl/mode_sequencer.sv
// Bring-up / programming sequencer: reset chain, UFM programming, inactive/active modes,
// a wait-state watchdog and per-channel enable overrides.
module mode_sequencer #(
    parameter int N_CH        = 2,
    parameter int TIMEOUT     = 50000,
    parameter int UFM_RST_CYC = 4,
    parameter int READ_WORDS  = 6
) (
    input  logic            clk,
    input  logic            reset,
    mode_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        ST_RST1     = 4'd0,
        ST_RST2     = 4'd1,
        ST_RST3     = 4'd2,
        ST_PROG1    = 4'd3,
        ST_PROG2    = 4'd4,
        ST_PROG3    = 4'd5,
        ST_INACTIVE = 4'd6,
        ST_ACTIVE   = 4'd7,
        ST_FAULT    = 4'd8
    } state_e;

    localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);
    localparam logic [3:0]  HOLD_LAST = 4'(UFM_RST_CYC);
    localparam logic [7:0]  RD_NEED   = 8'(READ_WORDS);

    // Plain 4-bit register so the unused codes 9..F stay representable and recoverable.
    logic [3:0]      state_q, state_d;
    logic [15:0]     wd_q, wd_d;
    logic [3:0]      hold_q, hold_d;
    logic [1:0]      led_q, led_d;
    logic [N_CH-1:0] fsm_en_q, fsm_en_d;
    logic [N_CH-1:0] ov_act_q, ov_act_d;
    logic [N_CH-1:0] ov_val_q, ov_val_d;
    logic            fault_q, fault_d;
    logic [3:0]      fault_code_q, fault_code_d;

    logic            exit_ok;
    logic [3:0]      exit_to;
    logic            wd_run;
    logic            timeout;
    logic            loaded;
    logic            run_cond;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RST1;
            wd_q         <= '0;
            hold_q       <= '0;
            led_q        <= 2'b00;
            fsm_en_q     <= '0;
            ov_act_q     <= '0;
            ov_val_q     <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= '0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            hold_q       <= hold_d;
            led_q        <= led_d;
            fsm_en_q     <= fsm_en_d;
            ov_act_q     <= ov_act_d;
            ov_val_q     <= ov_val_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    always_comb begin
        loaded   = bus.pot_loaded && bus.clk_loaded;
        run_cond = bus.clk_running && bus.sw_enable && !bus.sw_reset;
        exit_ok  = 1'b0;
        exit_to  = state_q;
        wd_run   = 1'b0;
        case (state_q)
            ST_RST1: begin
                exit_ok = bus.sw_enable_rise && bus.sw_reset;
                exit_to = ST_RST2;
            end
            ST_RST2: begin
                exit_ok = (hold_q == HOLD_LAST) && bus.pot_init && bus.clk_init;
                exit_to = ST_RST3;
                wd_run  = 1'b1;
            end
            ST_RST3: begin
                exit_ok = bus.csr_done && bus.pot_cfg_done;
                exit_to = ST_PROG1;
                wd_run  = 1'b1;
            end
            ST_PROG1: begin
                exit_ok = bus.write_done;
                exit_to = ST_PROG2;
            end
            ST_PROG2: begin
                exit_ok = bus.read_count >= RD_NEED;
                exit_to = ST_PROG3;
                wd_run  = 1'b1;
            end
            ST_PROG3: begin
                exit_ok = loaded && !bus.sw_reset && !bus.sw_enable;
                exit_to = ST_INACTIVE;
                wd_run  = !loaded;
            end
            ST_INACTIVE: begin
                exit_ok = bus.clk_idle && !bus.sw_reset && bus.sw_enable_rise;
                exit_to = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                exit_ok = bus.clk_running && !bus.sw_reset && !bus.sw_enable;
                exit_to = ST_PROG2;
            end
            ST_FAULT: exit_ok = 1'b0;
            default: begin
                exit_ok = 1'b1;
                exit_to = ST_RST1;
            end
        endcase

        // A real exit in the same cycle as the last watchdog count beats the timeout.
        timeout = wd_run && (wd_q == WD_LAST) && !exit_ok;
        state_d = state_q;
        if (bus.sw_reset_rise) begin
            state_d = ST_RST1;
        end else if (exit_ok) begin
            state_d = exit_to;
        end else if (timeout) begin
            state_d = ST_FAULT;
        end

        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        if (bus.sw_reset_rise) begin
            fault_d      = 1'b0;
            fault_code_d = '0;
        end else if (timeout) begin
            fault_d      = 1'b1;
            fault_code_d = state_q;
        end

        if (state_d != state_q) begin
            wd_d = '0;
        end else if (wd_run) begin
            wd_d = wd_q + 16'd1;
        end else if (state_q == ST_PROG3) begin
            wd_d = wd_q;
        end else begin
            wd_d = '0;
        end

        hold_d = '0;
        if (state_q == ST_RST2 && state_d == ST_RST2) begin
            hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 4'd1;
        end

        led_d = led_q;
        case (state_q)
            ST_RST1, ST_FAULT: led_d = 2'b00;
            ST_PROG1:          led_d = (state_d == ST_PROG2) ? 2'b10 : 2'b01;
            default:           led_d = led_q;
        endcase

        // Enables follow the state being entered so ch 0 is on from the first ACTIVE cycle.
        fsm_en_d = fsm_en_q;
        case (state_d)
            ST_RST1, ST_INACTIVE, ST_FAULT: fsm_en_d = '0;
            ST_ACTIVE: begin
                fsm_en_d[0] = 1'b1;
                if (state_q == ST_ACTIVE && run_cond) begin
                    fsm_en_d[N_CH-1:1] = '1;
                end
            end
            default: fsm_en_d = fsm_en_q;
        endcase

        // ov_wr / ov_clear are single-cycle strobes sampled every clock; clear wins over write.
        ov_act_d = ov_act_q;
        ov_val_d = ov_val_q;
        if (bus.ov_wr) begin
            ov_act_d = ov_act_q | bus.ov_mask;
            ov_val_d = (ov_val_q & ~bus.ov_mask) | (bus.ov_value & bus.ov_mask);
        end
        if (bus.ov_clear || bus.sw_reset_rise) begin
            ov_act_d = '0;
        end
    end

    assign bus.controlstate = state_q;
    assign bus.ufm_reset_n  = !((state_q == ST_RST1) ||
                                (state_q == ST_RST2 && hold_q != HOLD_LAST));
    assign bus.prog_led     = (state_q == ST_RST1 || state_q == ST_FAULT) ? 2'b00 :
                              (state_q == ST_PROG1) ? 2'b01 : led_q;
    assign bus.ch_en        = (state_q == ST_FAULT) ? '0 :
                              ((ov_act_q & ov_val_q) | (~ov_act_q & fsm_en_q));
    assign bus.fault        = fault_q;
    assign bus.fault_code   = fault_code_q;
    assign bus.ov_act_dbg   = ov_act_q;
    assign bus.fsm_en_dbg   = fsm_en_q;
endmodule

// File: tb/tb_mode_sequencer.sv
// Scenario bench for mode_sequencer: bring-up, re-program loop, overrides, watchdog, recovery.
module tb_mode_sequencer;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic       mon_en;
    logic [3:0] last_state;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    mode_sequencer_if #(.N_CH(2)) bus ();

    mode_sequencer #(
        .N_CH(2), .TIMEOUT(10), .UFM_RST_CYC(4), .READ_WORDS(6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // State-change monitor feeding the sequence scoreboard.
    always @(negedge clk) begin
        if (mon_en && bus.controlstate != last_state) got_q.push_back({4'd0, bus.controlstate});
        last_state = bus.controlstate;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sw_reset_rise = 1'b1;
        bus.ov_wr = 1'b1; bus.ov_mask = 2'b11; bus.ov_value = 2'b11;
        repeat (3) tick();
        vectors++; if (bus.controlstate !== 4'd0) begin miscompares++; $display("FAIL reset_state got=%h exp=0", bus.controlstate); end
        vectors++; if (bus.ufm_reset_n !== 1'b0) begin miscompares++; $display("FAIL reset_ufm got=%b exp=0", bus.ufm_reset_n); end
        vectors++; if (bus.prog_led !== 2'b00) begin miscompares++; $display("FAIL reset_led got=%b exp=00", bus.prog_led); end
        vectors++; if (bus.ch_en !== 2'b00) begin miscompares++; $display("FAIL reset_ch_en got=%b exp=00", bus.ch_en); end
        vectors++; if (bus.fault !== 1'b0 || bus.fault_code !== 4'd0) begin miscompares++; $display("FAIL reset_fault got=%b/%h exp=0/0", bus.fault, bus.fault_code); end
        vectors++; if (bus.ov_act_dbg !== 2'b00) begin miscompares++; $display("FAIL reset_ov_act got=%b exp=00", bus.ov_act_dbg); end
        bus.sw_reset_rise = 1'b0;
        bus.ov_wr = 1'b0; bus.ov_mask = 2'b00; bus.ov_value = 2'b00;
        reset = 1'b0;
        tick();
        vectors++; if (bus.controlstate !== 4'd0) begin miscompares++; $display("FAIL idle_after_reset got=%h exp=0", bus.controlstate); end
    endtask

    task automatic test_bring_up();
        int low_cnt;
        int n;
        logic [7:0] e;
        logic [7:0] g;
        mon_en = 1'b1;
        bus.pot_init = 1'b1; bus.clk_init = 1'b1; bus.clk_idle = 1'b1;
        bus.sw_reset = 1'b1; bus.sw_enable = 1'b1; bus.sw_enable_rise = 1'b1;
        exp_q.push_back(8'd1); exp_q.push_back(8'd2);
        tick();
        bus.sw_enable_rise = 1'b0;
        low_cnt = 0; n = 0;
        while (bus.controlstate == 4'd1 && n < 20) begin
            if (bus.ufm_reset_n === 1'b0) low_cnt++;
            tick();
            n++;
        end
        vectors++; if (low_cnt != 4) begin miscompares++; $display("FAIL ufm_low_cycles got=%0d exp=4", low_cnt); end
        vectors++; if (bus.controlstate !== 4'd2) begin miscompares++; $display("FAIL reach_rst3 got=%h exp=2", bus.controlstate); end
        bus.csr_done = 1'b1; bus.pot_cfg_done = 1'b1; exp_q.push_back(8'd3);
        tick();
        bus.csr_done = 1'b0; bus.pot_cfg_done = 1'b0;
        vectors++; if (bus.prog_led !== 2'b01) begin miscompares++; $display("FAIL led_prog1 got=%b exp=01", bus.prog_led); end
        bus.write_done = 1'b1; exp_q.push_back(8'd4);
        tick();
        bus.write_done = 1'b0;
        vectors++; if (bus.prog_led !== 2'b10) begin miscompares++; $display("FAIL led_prog2 got=%b exp=10", bus.prog_led); end
        bus.read_count = 8'd6; exp_q.push_back(8'd5);
        tick();
        bus.read_count = 8'd0;
        bus.pot_loaded = 1'b1; bus.clk_loaded = 1'b1;
        tick();
        vectors++; if (bus.controlstate !== 4'd5) begin miscompares++; $display("FAIL prog3_waits_switches got=%h exp=5", bus.controlstate); end
        bus.sw_reset = 1'b0; bus.sw_enable = 1'b0; exp_q.push_back(8'd6);
        tick();
        vectors++; if (bus.ch_en !== 2'b00) begin miscompares++; $display("FAIL inactive_ch_en got=%b exp=00", bus.ch_en); end
        bus.sw_enable = 1'b1; bus.sw_enable_rise = 1'b1; exp_q.push_back(8'd7);
        tick();
        bus.sw_enable_rise = 1'b0;
        vectors++; if (bus.ch_en !== 2'b01) begin miscompares++; $display("FAIL active_entry_ch_en got=%b exp=01", bus.ch_en); end
        tick();
        vectors++; if (bus.ch_en !== 2'b01) begin miscompares++; $display("FAIL active_wait_ch_en got=%b exp=01", bus.ch_en); end
        bus.clk_running = 1'b1; bus.clk_idle = 1'b0;
        tick();
        vectors++; if (bus.ch_en !== 2'b11) begin miscompares++; $display("FAIL active_run_ch_en got=%b exp=11", bus.ch_en); end
        tick();
        mon_en = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++; $display("FAIL state_seq got=none exp=%0d", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin miscompares++; $display("FAIL state_seq got=%0d exp=%0d", g, e); end
            end
        end
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL state_seq_extra got=%0d exp=0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_reprogram();
        bus.sw_enable = 1'b0;
        tick();
        vectors++; if (bus.controlstate !== 4'd4) begin miscompares++; $display("FAIL active_to_prog2 got=%h exp=4", bus.controlstate); end
        vectors++; if (bus.ch_en !== 2'b11) begin miscompares++; $display("FAIL prog2_ch_en_hold got=%b exp=11", bus.ch_en); end
        vectors++; if (bus.prog_led !== 2'b10) begin miscompares++; $display("FAIL prog2_led_hold got=%b exp=10", bus.prog_led); end
        bus.read_count = 8'd6;
        tick();
        bus.read_count = 8'd0;
        vectors++; if (bus.controlstate !== 4'd5) begin miscompares++; $display("FAIL reload_prog3 got=%h exp=5", bus.controlstate); end
        tick();
        vectors++; if (bus.controlstate !== 4'd6 || bus.ch_en !== 2'b00) begin miscompares++; $display("FAIL back_inactive got=%h/%b exp=6/00", bus.controlstate, bus.ch_en); end
    endtask

    task automatic test_override();
        logic [1:0] m;
        logic [1:0] v;
        logic       c;
        logic [1:0] m_act;
        logic [1:0] m_val;
        logic [7:0] e;
        bus.ov_wr = 1'b1; bus.ov_mask = 2'b10; bus.ov_value = 2'b10;
        tick();
        bus.ov_wr = 1'b0;
        vectors++; if (bus.ch_en !== 2'b10 || bus.ov_act_dbg !== 2'b10) begin miscompares++; $display("FAIL ov_set got=%b/%b exp=10/10", bus.ch_en, bus.ov_act_dbg); end
        bus.ov_wr = 1'b1; bus.ov_clear = 1'b1; bus.ov_mask = 2'b11; bus.ov_value = 2'b11;
        tick();
        bus.ov_wr = 1'b0; bus.ov_clear = 1'b0;
        vectors++; if (bus.ch_en !== 2'b00 || bus.ov_act_dbg !== 2'b00) begin miscompares++; $display("FAIL ov_clear_wins got=%b/%b exp=00/00", bus.ch_en, bus.ov_act_dbg); end
        m_act = 2'b00; m_val = 2'b00;
        for (int i = 0; i < 12; i++) begin
            m = 2'($urandom_range(0, 3));
            v = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 3) == 0);
            bus.ov_wr = 1'b1; bus.ov_mask = m; bus.ov_value = v; bus.ov_clear = c;
            if (c) begin
                m_act = 2'b00;
            end else begin
                m_act = m_act | m;
                m_val = (m_val & ~m) | (v & m);
            end
            exp_q.push_back({6'd0, m_act & m_val});
            tick();
            e = exp_q.pop_front();
            vectors++; if (bus.ch_en !== e[1:0]) begin miscompares++; $display("FAIL ov_random[%0d] got=%b exp=%b", i, bus.ch_en, e[1:0]); end
        end
        bus.ov_wr = 1'b0; bus.ov_clear = 1'b1;
        tick();
        bus.ov_clear = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.clk_idle = 1'b1; bus.clk_running = 1'b0;
        bus.sw_enable = 1'b1; bus.sw_enable_rise = 1'b1; bus.sw_reset_rise = 1'b1;
        tick();
        bus.sw_enable_rise = 1'b0; bus.sw_reset_rise = 1'b0;
        vectors++; if (bus.controlstate !== 4'd0) begin miscompares++; $display("FAIL swreset_priority got=%h exp=0", bus.controlstate); end
        bus.pot_init = 1'b0; bus.sw_reset = 1'b1; bus.sw_enable_rise = 1'b1;
        tick();
        bus.sw_enable_rise = 1'b0;
        repeat (9) tick();
        vectors++; if (bus.controlstate !== 4'd1) begin miscompares++; $display("FAIL wd_last_count got=%h exp=1", bus.controlstate); end
        bus.pot_init = 1'b1;
        tick();
        vectors++; if (bus.controlstate !== 4'd2 || bus.fault !== 1'b0) begin miscompares++; $display("FAIL exit_beats_timeout got=%h/%b exp=2/0", bus.controlstate, bus.fault); end
        bus.sw_reset_rise = 1'b1;
        tick();
        bus.sw_reset_rise = 1'b0;
        vectors++; if (bus.controlstate !== 4'd0) begin miscompares++; $display("FAIL swreset_from_rst3 got=%h exp=0", bus.controlstate); end
    endtask

    task automatic test_fault_mask();
        int n;
        bus.ov_wr = 1'b1; bus.ov_mask = 2'b11; bus.ov_value = 2'b11;
        tick();
        bus.ov_wr = 1'b0;
        vectors++; if (bus.ch_en !== 2'b11) begin miscompares++; $display("FAIL ov_full got=%b exp=11", bus.ch_en); end
        bus.pot_init = 1'b0; bus.sw_reset = 1'b1; bus.sw_enable_rise = 1'b1;
        tick();
        bus.sw_enable_rise = 1'b0;
        vectors++; if (bus.controlstate !== 4'd1) begin miscompares++; $display("FAIL enter_rst2 got=%h exp=1", bus.controlstate); end
        n = 0;
        while (bus.controlstate != 4'd8 && n < 30) begin
            tick();
            n++;
        end
        vectors++; if (n != 10) begin miscompares++; $display("FAIL timeout_cycles got=%0d exp=10", n); end
        vectors++; if (bus.fault !== 1'b1 || bus.fault_code !== 4'd1) begin miscompares++; $display("FAIL fault_code got=%b/%h exp=1/1", bus.fault, bus.fault_code); end
        vectors++; if (bus.ch_en !== 2'b00) begin miscompares++; $display("FAIL fault_mask got=%b exp=00", bus.ch_en); end
        vectors++; if (bus.ov_act_dbg !== 2'b11) begin miscompares++; $display("FAIL fault_ov_kept got=%b exp=11", bus.ov_act_dbg); end
        vectors++; if (bus.prog_led !== 2'b00) begin miscompares++; $display("FAIL fault_led got=%b exp=00", bus.prog_led); end
        bus.ov_wr = 1'b1; bus.ov_mask = 2'b01; bus.ov_value = 2'b00;
        tick();
        bus.ov_wr = 1'b0;
        repeat (2) tick();
        vectors++; if (bus.controlstate !== 4'd8 || bus.fault !== 1'b1 || bus.ch_en !== 2'b00) begin miscompares++; $display("FAIL fault_hold got=%h/%b/%b exp=8/1/00", bus.controlstate, bus.fault, bus.ch_en); end
        vectors++; if (bus.ov_act_dbg !== 2'b11) begin miscompares++; $display("FAIL fault_ov_store got=%b exp=11", bus.ov_act_dbg); end
        bus.sw_reset_rise = 1'b1;
        tick();
        bus.sw_reset_rise = 1'b0;
        vectors++; if (bus.controlstate !== 4'd0 || bus.fault !== 1'b0 || bus.fault_code !== 4'd0) begin miscompares++; $display("FAIL fault_recover got=%h/%b/%h exp=0/0/0", bus.controlstate, bus.fault, bus.fault_code); end
        vectors++; if (bus.ov_act_dbg !== 2'b00) begin miscompares++; $display("FAIL recover_ov_clear got=%b exp=00", bus.ov_act_dbg); end
        bus.pot_init = 1'b1;
    endtask

    task automatic test_illegal();
        int n;
        force dut.state_q = 4'hB;
        #1;
        release dut.state_q;
        tick();
        vectors++; if (bus.controlstate !== 4'd0) begin miscompares++; $display("FAIL illegal_recover got=%h exp=0", bus.controlstate); end
        bus.sw_reset = 1'b1; bus.sw_enable_rise = 1'b1;
        tick();
        bus.sw_enable_rise = 1'b0;
        n = 0;
        while (bus.controlstate != 4'd2 && n < 20) begin
            tick();
            n++;
        end
        vectors++; if (bus.controlstate !== 4'd2) begin miscompares++; $display("FAIL reach_rst3_again got=%h exp=2", bus.controlstate); end
        bus.csr_done = 1'b1; bus.pot_cfg_done = 1'b1;
        tick();
        bus.csr_done = 1'b0; bus.pot_cfg_done = 1'b0;
        vectors++; if (bus.controlstate !== 4'd3 || bus.prog_led !== 2'b01) begin miscompares++; $display("FAIL prog1_again got=%h/%b exp=3/01", bus.controlstate, bus.prog_led); end
        bus.sw_reset_rise = 1'b1;
        tick();
        bus.sw_reset_rise = 1'b0;
        vectors++; if (bus.controlstate !== 4'd0 || bus.prog_led !== 2'b00) begin miscompares++; $display("FAIL prog1_abort got=%h/%b exp=0/00", bus.controlstate, bus.prog_led); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        mon_en = 1'b0; last_state = 4'd0;
        reset = 1'b1;
        bus.sw_reset = 1'b0; bus.sw_enable = 1'b0;
        bus.sw_reset_rise = 1'b0; bus.sw_enable_rise = 1'b0;
        bus.pot_init = 1'b0; bus.clk_init = 1'b0;
        bus.csr_done = 1'b0; bus.pot_cfg_done = 1'b0; bus.write_done = 1'b0;
        bus.read_count = 8'd0;
        bus.pot_loaded = 1'b0; bus.clk_loaded = 1'b0;
        bus.clk_idle = 1'b0; bus.clk_running = 1'b0;
        bus.ov_wr = 1'b0; bus.ov_mask = 2'b00; bus.ov_value = 2'b00; bus.ov_clear = 1'b0;
        test_reset();
        test_bring_up();
        test_reprogram();
        test_override();
        test_back_to_back();
        test_fault_mask();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
